pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 5 +
 rtl/pwm_sync_edge.sv | 22 ++
 rtl/pwm_capture.sv | 86 ++++++++
 tb/tb_pwm_capture.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM timer types and default counter width
package pwm_pkg;
  localparam int PWM_W = 16;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} cap_state_t;
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: optional 2-flop input synchronizer plus rise/fall edge detection
// Define PWM_CAPTURE_SYNC_EN to insert the synchronizer for asynchronous pins.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pwm,
  output logic o_rise,
  output logic o_fall
);
  logic w_s;
  logic r_s_d;
`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk) r_sync <= rst ? 2'b00 : {r_sync[0], i_pwm};
  assign w_s = r_sync[1];
`else
  assign w_s = i_pwm;
`endif
  always_ff @(posedge clk) r_s_d <= rst ? 1'b0 : w_s;
  assign o_rise = w_s & ~r_s_d;
  assign o_fall = ~w_s & r_s_d;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period and high time in clk cycles, with saturation timeout
// Input synchronizer depth is selected by PWM_CAPTURE_SYNC_EN inside pwm_sync_edge.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high,
  output logic         valid,
  output logic         timeout
);
  localparam logic [W-1:0] MAX = '1;
  cap_state_t r_state, w_next;
  logic [W-1:0] r_cnt, r_hi_cnt, w_cnt, w_hi_cnt, w_period, w_high;
  logic w_rise, w_fall, w_valid, w_timeout, w_sat;
  pwm_sync_edge u_edge (
    .clk   (clk),
    .rst   (rst),
    .i_pwm (pwm_in),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );
  assign w_sat = r_cnt == MAX;
  // an awaited edge at cnt == MAX wins over saturation; cnt holds at MAX instead of wrapping
  always_comb begin
    w_next    = r_state;
    w_cnt     = w_sat ? r_cnt : r_cnt + 1'b1;
    w_hi_cnt  = r_hi_cnt;
    w_period  = period;
    w_high    = high;
    w_valid   = 1'b0;
    w_timeout = timeout;
    case (r_state)
      IDLE: begin
        w_cnt  = w_rise ? W'(1) : r_cnt;
        w_next = w_rise ? HIGH : IDLE;
      end
      HIGH: begin
        if (w_fall) begin
          w_hi_cnt = r_cnt;
          w_next   = LOW;
        end else if (w_sat) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_period  = r_cnt;
          w_high    = r_hi_cnt;
          w_valid   = 1'b1;
          w_timeout = 1'b0;
          w_cnt     = W'(1);
          w_next    = HIGH;
        end else if (w_sat) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi_cnt <= '0;
      period   <= '0;
      high     <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_hi_cnt <= w_hi_cnt;
      period   <= w_period;
      high     <= w_high;
      valid    <= w_valid;
      timeout  <= w_timeout;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed checks of pwm_capture against an edge-timestamp model
module tb_pwm_capture;
  localparam int W = 8;
  localparam int MAX = (1 << W) - 1;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pwm_in = 1'b0;
  logic [W-1:0] period, high;
  logic valid, timeout;
  logic [2*W+1:0] got, want;
  int tests = 0;
  int failed = 0;
  int n = 0;
  logic m_prev, m_meas, m_seen_fall, m_v, m_t;
  logic [W-1:0] m_p, m_h;
  int m_rise_t, m_fall_t;
  logic [2*W+1:0] pipe[$];

  pwm_capture #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .period (period),
    .high   (high),
    .valid  (valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;
  assign got = {valid, timeout, period, high};

  task automatic do_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    {m_prev, m_meas, m_seen_fall, m_v, m_t} = '0;
    m_p = '0;
    m_h = '0;
    n = 0;
    pipe.delete();
    repeat (D) pipe.push_back('0);
  endtask

  // model works on pin-edge timestamps; want is the expectation for the outputs seen now
  task automatic drive(input logic v);
    logic r, f, aw;
    pwm_in = v;
    r = v & ~m_prev;
    f = ~v & m_prev;
    m_prev = v;
    m_v = 1'b0;
    if (m_meas) begin
      aw = m_seen_fall ? r : f;
      if (n - m_rise_t >= MAX && !aw) begin
        m_t = 1'b1;
        m_meas = 1'b0;
      end else begin
        if (f) begin
          m_fall_t = n;
          m_seen_fall = 1'b1;
        end
        if (r) begin
          if (m_seen_fall) begin
            m_p = W'(n - m_rise_t);
            m_h = W'(m_fall_t - m_rise_t);
            m_v = 1'b1;
            m_t = 1'b0;
          end
          m_rise_t = n;
          m_seen_fall = 1'b0;
        end
      end
    end else if (r) begin
      m_meas = 1'b1;
      m_rise_t = n;
      m_seen_fall = 1'b0;
    end
    pipe.push_back({m_v, m_t, m_p, m_h});
    @(posedge clk); #1;
    n++;
    want = pipe.pop_front();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (got !== '0) begin failed++; $display("FAIL reset: got %h want 0", got); end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1);
      tests++;
      if (got !== want) begin failed++; $display("FAIL reset_high step %0d: got %h want %h", n, got, want); end
    end
  endtask

  task automatic test_loopback();
    int cnt = 0;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      drive((c % 10) < 3);
      tests++;
      if (got !== want) begin failed++; $display("FAIL loopback step %0d: got %h want %h", n, got, want); end
      if (valid && period == 10 && high == 3) cnt++;
    end
    tests++;
    if (cnt != 6) begin failed++; $display("FAIL loopback_count: got %0d want 6", cnt); end
  endtask

  task automatic test_min_period();
    int cnt = 0;
    do_reset();
    for (int c = 0; c < 44; c++) begin
      drive(c < 40 && (c % 2) == 0);
      tests++;
      if (got !== want) begin failed++; $display("FAIL min_period step %0d: got %h want %h", n, got, want); end
      if (valid && period == 2 && high == 1) cnt++;
    end
    tests++;
    if (cnt != 19) begin failed++; $display("FAIL min_period_count: got %0d want 19", cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      drive(1'b1);
      tests++;
      if (got !== want) begin failed++; $display("FAIL timeout_hold step %0d: got %h want %h", n, got, want); end
    end
    tests++;
    if (timeout !== 1'b1) begin failed++; $display("FAIL timeout_set: got %b want 1", timeout); end
    for (int c = 0; c < 40; c++) begin
      drive((c % 7) >= 4);
      tests++;
      if (got !== want) begin failed++; $display("FAIL timeout_recover step %0d: got %h want %h", n, got, want); end
    end
    tests++;
    if ({timeout, period, high} !== {1'b0, 8'd7, 8'd3})
      begin failed++; $display("FAIL timeout_clear: got t=%b p=%0d h=%0d want t=0 p=7 h=3", timeout, period, high); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 25; c++) begin
      drive((c % 10) < 4);
      tests++;
      if (got !== want) begin failed++; $display("FAIL reset_mid_pre step %0d: got %h want %h", n, got, want); end
    end
    do_reset();
    tests++;
    if (got !== '0) begin failed++; $display("FAIL reset_mid_zero: got %h want 0", got); end
    for (int c = 25; c < 64; c++) begin
      drive((c % 10) < 4);
      tests++;
      if (got !== want) begin failed++; $display("FAIL reset_mid_post step %0d: got %h want %h", n, got, want); end
    end
  endtask

  task automatic test_max_period();
    bit wave[$];
    bit saw_to = 0;
    int lows[4] = '{155, 155, 156, 155};
    do_reset();
    foreach (lows[i]) begin
      repeat (100) wave.push_back(1'b1);
      repeat (lows[i]) wave.push_back(1'b0);
    end
    repeat (5) wave.push_back(1'b1);
    repeat (10) wave.push_back(1'b0);
    foreach (wave[i]) begin
      drive(wave[i]);
      tests++;
      if (got !== want) begin failed++; $display("FAIL max_period step %0d: got %h want %h", n, got, want); end
      if (timeout) saw_to = 1;
    end
    tests++;
    if (!saw_to || timeout !== 1'b0 || period !== 8'd255)
      begin failed++; $display("FAIL max_period_end: got saw_to=%b t=%b p=%0d want 1 0 255", saw_to, timeout, period); end
  endtask

  task automatic test_random();
    bit wave[$];
    do_reset();
    repeat (40) begin
      repeat ($urandom_range(1, 12)) wave.push_back(1'b1);
      repeat ($urandom_range(1, 12)) wave.push_back(1'b0);
    end
    foreach (wave[i]) begin
      drive(wave[i]);
      tests++;
      if (got !== want) begin failed++; $display("FAIL random step %0d: got %h want %h", n, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_min_period();
    test_timeout();
    test_reset_mid();
    test_max_period();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
